// File: rtl/sha256_core_pipe_if.sv
// Handshake and data bundle between the nonce controller and the SHA-256 core.
// The controller side takes the master modport; the core takes the slave modport.
interface sha256_core_pipe_if;
    logic         start;
    logic [511:0] block_in;
    logic [255:0] state_in;
    logic         busy;
    logic         done;
    logic [255:0] digest_out;

    modport master (output start, block_in, state_in, input busy, done, digest_out);
    modport slave  (input start, block_in, state_in, output busy, done, digest_out);
endinterface

// File: rtl/sha256_core_pipe.sv
// Iterative SHA-256 compression engine.
// Each ROUND cycle evaluates UNROLL rounds as one combinational chain.
// A 16-word message schedule window slides forward by UNROLL words per cycle.
// Multi-block messages are chained by the caller: it feeds digest_out back in as state_in.
//
// state | meaning
// IDLE  | waiting for start; digest_out holds the last result
// ROUND | UNROLL rounds per edge, ROUNDS_CYC edges in total
// FINAL | add the working registers to the H latch, pulse done
module sha256_core_pipe #(
    parameter int UNROLL = 1
) (
    input logic               clk,
    input logic               rst,
    sha256_core_pipe_if.slave bus
);
    localparam int ROUNDS_CYC = 64 / UNROLL;

    if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4 && UNROLL != 8) begin : g_bad_unroll
        $error("sha256_core_pipe: UNROLL must be 1, 2, 4 or 8");
    end

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

    state_t       state;
    logic [5:0]   cnt;
    logic         busy_r;
    logic         done_r;
    logic [255:0] digest_r;
    logic [31:0]  w      [16];
    logic [31:0]  hv     [8];
    logic [31:0]  wv     [8];
    logic [31:0]  w_nxt  [16];
    logic [31:0]  wv_nxt [8];
    logic [31:0]  ext    [16+UNROLL];
    logic [31:0]  rv     [8];
    logic [31:0]  t1;
    logic [31:0]  t2;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Schedule extension and UNROLL chained rounds starting at t = cnt*UNROLL.
    // The extended array holds the 16 window words plus the UNROLL words that
    // come next. New words may depend on earlier new words, so they are built in order.
    always_comb begin
        for (int i = 0; i < 16; i++) ext[i] = w[i];
        for (int j = 0; j < UNROLL; j++)
            ext[16+j] = ssig1(ext[14+j]) + ext[9+j] + ssig0(ext[1+j]) + ext[j];
        for (int i = 0; i < 16; i++) w_nxt[i] = ext[i+UNROLL];
        rv = wv;
        t1 = '0;
        t2 = '0;
        for (int i = 0; i < UNROLL; i++) begin
            t1 = rv[7] + bsig1(rv[4]) + ((rv[4] & rv[5]) ^ (~rv[4] & rv[6]))
               + K[6'(int'(cnt) * UNROLL + i)] + ext[i];
            t2 = bsig0(rv[0]) + ((rv[0] & rv[1]) ^ (rv[0] & rv[2]) ^ (rv[1] & rv[2]));
            rv[7] = rv[6];
            rv[6] = rv[5];
            rv[5] = rv[4];
            rv[4] = rv[3] + t1;
            rv[3] = rv[2];
            rv[2] = rv[1];
            rv[1] = rv[0];
            rv[0] = t1 + t2;
        end
        wv_nxt = rv;
    end

    // Control FSM with the datapath registers and registered outputs.
    // A reset while a block is in flight discards that block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            digest_r <= '0;
            for (int i = 0; i < 16; i++) w[i] <= '0;
            for (int i = 0; i < 8; i++) begin
                hv[i] <= '0;
                wv[i] <= '0;
            end
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        for (int i = 0; i < 16; i++) w[i] <= bus.block_in[511-32*i -: 32];
                        for (int i = 0; i < 8; i++) begin
                            wv[i] <= bus.state_in[255-32*i -: 32];
                            hv[i] <= bus.state_in[255-32*i -: 32];
                        end
                        cnt    <= '0;
                        busy_r <= 1'b1;
                        state  <= ROUND;
                    end
                end
                ROUND: begin
                    w   <= w_nxt;
                    wv  <= wv_nxt;
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'(ROUNDS_CYC - 1)) state <= FINAL;
                end
                FINAL: begin
                    for (int i = 0; i < 8; i++) digest_r[255-32*i -: 32] <= hv[i] + wv[i];
                    done_r <= 1'b1;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.digest_out = digest_r;
endmodule
